// File: rtl/gray_bin_pipe.sv
// -----------------------------------------------------------------------------
// gray_bin_pipe
// Parametrised, pipelined Gray<->binary converter with valid/ready flow control.
// Each word selects its own direction. The conversion is done combinationally
// on the input side and registered into stage 0. The remaining stages only
// move data forward, so out_data has no combinational path from in_data.
//
// Parameters
//   WIDTH   data width in bits (>= 2), default 8
//   STAGES  number of pipeline register stages (>= 1), default 2; sets latency
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   input word present
//   in_ready   block can accept a word this cycle (stage-0 load enable)
//   in_data    Gray code (mode=0) or binary (mode=1)
//   mode       0: Gray->binary, 1: binary->Gray, sampled with in_data
//   out_valid  output word present
//   out_ready  downstream accepts the output word
//   out_data   converted word
//   out_mode   mode the current output word was converted with
//   step_err   Gray step violation flag for the current output word
//
// Optional feature, selected by macro GRAY_STEP_CHECK_EN
//   Defined:   a history register keeps the Gray form of the last accepted
//              word. Each accepted word is flagged unless its Gray form
//              differs from that history in exactly one bit. The flag travels
//              with the word and appears on step_err.
//   Undefined: no history logic, and step_err is tied to 0.
// -----------------------------------------------------------------------------
module gray_bin_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             step_err
);

  localparam int LAST = STAGES - 1;

  // Gray->binary: each binary bit is the XOR of all Gray bits at or above it.
  // The running XOR starts from the MSB and works downward.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary->Gray: XOR of each bit with its upper neighbour.
  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Pipeline storage. stage_v[i] marks stage i as holding a real word.
  logic [STAGES-1:0] stage_v;
  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [STAGES-1:0] stage_mode;
  logic [STAGES-1:0] load;
  logic              tail_full;
  logic [WIDTH-1:0]  conv_data;

  // Converted input word. This is the only combinational logic on the data path.
  // It feeds stage 0 directly.
  always_comb begin
    conv_data = mode ? bin_to_gray(in_data) : gray_to_bin(in_data);
  end

  // Load enables.
  // A stage may load when any stage from it up to the output is empty, or when
  // the output is being drained. This is the unrolled form of
  // "load[i] = !v[i] || load[i+1]". Bubbles collapse, and in_ready depends only
  // on registered valids and out_ready. It never depends on in_valid.
  always_comb begin
    load      = '0;
    tail_full = 1'b1;
    for (int i = LAST; i >= 0; i--) begin
      tail_full = tail_full & stage_v[i];
      load[i]   = out_ready | ~tail_full;
    end
  end

  assign in_ready = load[0];

  // Pipeline registers.
  // Stage 0 captures the converted input. Every later stage copies its
  // predecessor when enabled, which includes copying the predecessor's valid
  // bit, so an empty predecessor moves a bubble forward. Reset clears every
  // stage, so in-flight words and any word offered on the reset edge are lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_v    <= '0;
      stage_mode <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stage_data[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        stage_v[0]    <= in_valid;
        stage_data[0] <= conv_data;
        stage_mode[0] <= mode;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          stage_v[i]    <= stage_v[i-1];
          stage_data[i] <= stage_data[i-1];
          stage_mode[i] <= stage_mode[i-1];
        end
      end
    end
  end

  assign out_valid = stage_v[LAST];
  assign out_data  = stage_data[LAST];
  assign out_mode  = stage_mode[LAST];

`ifdef GRAY_STEP_CHECK_EN

  // Number of set bits in a word. A legal Gray step has exactly one set bit
  // in the XOR of two consecutive codes.
  function automatic int ones(input logic [WIDTH-1:0] x);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) n++;
    end
    return n;
  endfunction

  logic [WIDTH-1:0]  hist_gray;
  logic              hist_valid;
  logic              hist_mode;
  logic [WIDTH-1:0]  in_gray;
  logic              hist_live;
  logic              in_err;
  logic              accept;
  logic [STAGES-1:0] stage_err;

  // Step check on the Gray form of the incoming word.
  // For mode=1 the Gray form is the converted output. For mode=0 it is the
  // input itself. History only counts if the previous accepted word used the
  // same mode, so the first word after a mode change is never flagged.
  // A repeated code has zero differing bits and is flagged.
  always_comb begin
    in_gray   = mode ? conv_data : in_data;
    hist_live = hist_valid && (hist_mode == mode);
    in_err    = hist_live && (ones(in_gray ^ hist_gray) != 1);
    accept    = in_valid && load[0];
  end

  // History register. It updates only on real transfers and is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_gray  <= '0;
      hist_valid <= 1'b0;
      hist_mode  <= 1'b0;
    end else if (accept) begin
      hist_gray  <= in_gray;
      hist_valid <= 1'b1;
      hist_mode  <= mode;
    end
  end

  // The error flag moves alongside the data, using the same load enables,
  // so it stays attached to its own word under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_err <= '0;
    end else begin
      if (load[0]) begin
        stage_err[0] <= in_err;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          stage_err[i] <= stage_err[i-1];
        end
      end
    end
  end

  assign step_err = stage_err[LAST];

`else

  assign step_err = 1'b0;

`endif

endmodule

// File: tb/tb_gray_bin_pipe.sv
// -----------------------------------------------------------------------------
// tb_gray_bin_pipe
// Self-checking bench for gray_bin_pipe with WIDTH=4 and STAGES=2.
// Single-word vectors come from a table, and the latency of each one is
// measured. Streams are checked against a reference model that keeps a queue
// of expected words. The model inverts Gray codes by searching for the binary
// value whose Gray code matches.
// -----------------------------------------------------------------------------
module tb_gray_bin_pipe;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_mode;
  logic         step_err;

  int checks   = 0;
  int failures = 0;

  gray_bin_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .step_err  (step_err)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so that a stuck design cannot hang the run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic         m;
    logic [W-1:0] din;
    logic [W-1:0] dout;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         m;
    logic         err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: the Gray form of the last accepted word.
  logic [W-1:0] m_hist;
  logic         m_hist_valid;
  logic         m_hist_mode;

  // State for the hold check and for stream bookkeeping.
  logic         stalled_prev;
  logic [W-1:0] held_data;
  logic         held_mode;
  logic         held_err;
  logic         last_accept;
  logic         last_in_ready;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray->binary found by search: the binary value whose Gray code is g.
  function automatic logic [W-1:0] model_g2b(input logic [W-1:0] g);
    logic [W-1:0] cand;
    for (int b = 0; b < (1 << W); b++) begin
      cand = b[W-1:0];
      if (model_gray(cand) == g) return cand;
    end
    return '0;
  endfunction

  // Queues the expected output for an accepted word and updates the model history.
  task automatic model_accept(input logic [W-1:0] d, input logic m);
    exp_t         e;
    logic [W-1:0] g;
    g      = m ? model_gray(d) : d;
    e.data = m ? model_gray(d) : model_g2b(d);
    e.m    = m;
`ifdef GRAY_STEP_CHECK_EN
    e.err  = m_hist_valid && (m_hist_mode == m) && ($countones(g ^ m_hist) != 1);
`else
    e.err  = 1'b0;
`endif
    m_hist       = g;
    m_hist_valid = 1'b1;
    m_hist_mode  = m;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_hist       = '0;
    m_hist_valid = 1'b0;
    m_hist_mode  = 1'b0;
    stalled_prev = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_data"},  32'(out_data),  32'd0);
    checkOutput({tag, "_out_mode"},  32'(out_mode),  32'd0);
    checkOutput({tag, "_step_err"},  32'(step_err),  32'd0);
    checkOutput({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  // Runs one reset cycle. in_valid stays high on the reset edge so that the
  // word offered there must be dropped.
  task automatic pulse_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b0011;
    mode     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
  endtask

  // Runs one streaming cycle. Inputs are driven at the negedge. The bench then
  // samples, scores any output transfer, checks that stalled outputs hold
  // steady, and records any input transfer in the model.
  task automatic step_cycle(input logic iv, input logic [W-1:0] d, input logic m, input logic ordy);
    exp_t e;
    in_valid  = iv;
    in_data   = d;
    mode      = m;
    out_ready = ordy;
    #1;
    if (stalled_prev) begin
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_data",  32'(out_data),  32'(held_data));
      checkOutput("hold_mode",  32'(out_mode),  32'(held_mode));
      checkOutput("hold_err",   32'(step_err),  32'(held_err));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("stream_data", 32'(out_data), 32'(e.data));
        checkOutput("stream_mode", 32'(out_mode), 32'(e.m));
        checkOutput("stream_err",  32'(step_err), 32'(e.err));
      end
    end
    stalled_prev  = out_valid && !out_ready;
    held_data     = out_data;
    held_mode     = out_mode;
    held_err      = step_err;
    last_in_ready = in_ready;
    last_accept   = in_valid && in_ready;
    if (last_accept) model_accept(d, m);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid); i++) begin
      step_cycle(1'b0, '0, 1'b0, 1'b1);
    end
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Sends one word into an empty pipeline with out_ready=1, measures the
  // latency to out_valid, and returns the output word.
  task automatic applyStimulus(input logic m, input logic [W-1:0] d,
                               output logic [W-1:0] got_data, output logic got_mode,
                               output logic got_err);
    int cnt;
    in_valid  = 1'b1;
    in_data   = d;
    mode      = m;
    out_ready = 1'b1;
    #1;
    checkOutput("single_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    checkOutput("single_latency", 32'(cnt), 32'(S));
    got_data = out_data;
    got_mode = out_mode;
    got_err  = step_err;
  endtask

  initial begin
    vec_t         vecs[6];
    logic [W-1:0] gd, rd;
    logic         gm, ge;
    logic         t6_err[6];
    logic [W-1:0] t6_data[6];
    logic         t6_mode[6];
    int           k;
    int           acc;
    logic         m_cur;

    vecs[0] = '{m: 1'b0, din: 4'b1011, dout: 4'b1101};
    vecs[1] = '{m: 1'b1, din: 4'b1101, dout: 4'b1011};
    vecs[2] = '{m: 1'b0, din: 4'b0000, dout: 4'b0000};
    vecs[3] = '{m: 1'b1, din: 4'b1111, dout: 4'b1000};
    vecs[4] = '{m: 1'b0, din: 4'b1000, dout: 4'b1111};
    vecs[5] = '{m: 1'b1, din: 4'b0110, dout: 4'b0101};

    t6_data = '{4'b0000, 4'b0001, 4'b0111, 4'b0111, 4'b0110, 4'b1111};
    t6_mode = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef GRAY_STEP_CHECK_EN
    t6_err  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    t6_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 1'b0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("reset");

    // Table vectors, including the two worked examples.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].m, vecs[i].din, gd, gm, ge);
      checkOutput($sformatf("vec%0d_data", i), 32'(gd), 32'(vecs[i].dout));
      checkOutput($sformatf("vec%0d_mode", i), 32'(gm), 32'(vecs[i].m));
    end

    // Exhaustive sweep in both directions, and a round trip through the DUT.
    for (int v = 0; v < 16; v++) begin
      applyStimulus(1'b0, v[W-1:0], gd, gm, ge);
      checkOutput($sformatf("sweep_g2b_%0d", v), 32'(gd), 32'(model_g2b(v[W-1:0])));
      applyStimulus(1'b1, v[W-1:0], gd, gm, ge);
      checkOutput($sformatf("sweep_b2g_%0d", v), 32'(gd), 32'(model_gray(v[W-1:0])));
      applyStimulus(1'b0, gd, rd, gm, ge);
      checkOutput($sformatf("round_trip_%0d", v), 32'(rd), 32'(v));
    end

    // Gray step flags on a hand-written sequence, ending with a mode toggle.
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(t6_mode[i], t6_data[i], gd, gm, ge);
      checkOutput($sformatf("step_seq%0d_err", i), 32'(ge), 32'(t6_err[i]));
    end

    // Full-rate stream of Gray 0..15. in_ready must stay high throughout.
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      step_cycle(1'b1, model_gray(i[W-1:0]), 1'b0, 1'b1);
      checkOutput($sformatf("stream_in_ready%0d", i), 32'(last_in_ready), 32'd1);
    end
    drain();

    // Backpressure starting from an empty pipeline. Only S words get in.
    k   = 0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      step_cycle(1'b1, model_gray(k[W-1:0]), 1'b0, 1'b0);
      if (last_accept) begin
        k++;
        acc++;
      end
    end
    checkOutput("stall_accepts",  32'(acc), 32'(S));
    checkOutput("stall_in_ready", 32'(last_in_ready), 32'd0);
    for (int i = 0; i < 40 && k < 12; i++) begin
      step_cycle(1'b1, model_gray(k[W-1:0]), 1'b0, (i % 7) > 1);
      if (last_accept) k++;
    end
    checkOutput("stall_words_sent", 32'(k), 32'd12);
    drain();

    // Reset with the pipeline full. The post-reset word must convert cleanly.
    for (int i = 0; i < 3; i++) step_cycle(1'b1, 4'b0101, 1'b0, 1'b0);
    out_ready = 1'b0;
    pulse_reset();
    check_idle("midreset");
    step_cycle(1'b1, 4'b1011, 1'b0, 1'b1);
    drain();

    // Random traffic against the model.
    m_cur = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) m_cur = ~m_cur;
      step_cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), m_cur,
                 $urandom_range(0, 3) != 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
